// File: rtl/pipeline_spi_command_master.sv
// SPI mode-0 command master: one frame of up to MAX_BYTES bytes per handshake,
// MSB-first on MOSI, MISO captured into rsp_data with matching byte alignment.
module pipeline_spi_command_master #(
    parameter int CLK_DIV    = 4,
    parameter int MAX_BYTES  = 8,
    parameter int GAP_CYCLES = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic [8*MAX_BYTES-1:0] rsp_data,
    output logic                   rsp_valid,
    output logic                   busy,
    output logic                   hw_spi_clk,
    output logic                   hw_spi_ss,
    output logic                   hw_spi_mosi,
    input  logic                   hw_spi_miso
);

    localparam int NB    = 8 * MAX_BYTES;
    localparam int IDX_W = $clog2(NB);
    localparam int BIT_W = $clog2(NB + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [BIT_W-1:0] nbits_q, nbits_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [NB-1:0]    tx_q, tx_d;
    logic [NB-1:0]    rsp_q, rsp_d;
    logic             sclk_q, sclk_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             rv_q, rv_d;

    logic [LEN_WIDTH-1:0] len_eff;
    logic [BIT_W-1:0]     nbits_in;
    logic [BIT_W-1:0]     bit_inc;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic                 div_last;
    logic                 last_bit;

    // Frame bit k lives at byte k/8, bit 7-k%8: flip the low three index bits.
    always_comb begin
        len_eff  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        nbits_in = BIT_W'({len_eff, 3'b000});
        bit_inc  = bit_q + 1'b1;
        cur_idx  = bit_q[IDX_W-1:0] ^ IDX_W'(7);
        nxt_idx  = bit_inc[IDX_W-1:0] ^ IDX_W'(7);
        div_last = (div_q == DIV_LAST);
        last_bit = (bit_q == nbits_q - BIT_W'(1));
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rsp_d   = rsp_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        rv_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                div_d   = '0;
                if (cmd_valid && ready_q) begin
                    tx_d    = cmd_data;
                    rsp_d   = '0;
                    nbits_d = nbits_in;
                    bit_d   = '0;
                    if (len_eff == '0) begin
                        rv_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        ss_d    = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = cmd_data[7];
                    end
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_d = S_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    rsp_d[cur_idx] = hw_spi_miso;
                end
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (last_bit) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_inc;
                        mosi_d  = tx_q[nxt_idx];
                    end
                end
            end
            S_LOW: begin
                if (div_last) begin
                    state_d = S_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    div_d  = '0;
                    ss_d   = 1'b1;
                    mosi_d = 1'b0;
                    rv_d   = 1'b1;
                    gap_d  = '0;
                    // The IDLE cycle itself is the last cycle of the ss-high gap.
                    if (GAP_CYCLES > 1) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rsp_q   <= '0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rsp_q   <= rsp_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_data    = rsp_q;
    assign rsp_valid   = rv_q;
    assign busy        = busy_q;
    assign hw_spi_clk  = sclk_q;
    assign hw_spi_ss   = ss_q;
    assign hw_spi_mosi = mosi_q;

endmodule

// File: tb/tb_pipeline_spi_command_master.sv
// Directed bench for pipeline_spi_command_master with a mode-0 MISO slave model
// and monitors for SPI edges, MOSI bits, ss-low cycles and rsp_valid pulses.
module tb_pipeline_spi_command_master;

    localparam int CLK_DIV    = 2;
    localparam int MAX_BYTES  = 8;
    localparam int GAP_CYCLES = 4;
    localparam int LEN_WIDTH  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len = '0;
    logic [63:0]          cmd_data = '0;
    logic [63:0]          rsp_data;
    logic                 rsp_valid;
    logic                 busy;
    logic                 hw_spi_clk;
    logic                 hw_spi_ss;
    logic                 hw_spi_mosi;
    logic                 hw_spi_miso;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] miso_pat = '0;
    logic [63:0] mosi_log = '0;
    logic        sclk_prev = 1'b0;
    int          miso_idx = 0;
    int          rise_cnt = 0;
    int          ss_low_cnt = 0;
    int          rv_cnt = 0;
    int          mi;

    always #5 clk = ~clk;

    pipeline_spi_command_master #(
        .CLK_DIV(CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .GAP_CYCLES(GAP_CYCLES),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .rsp_data(rsp_data),
        .rsp_valid(rsp_valid),
        .busy(busy),
        .hw_spi_clk(hw_spi_clk),
        .hw_spi_ss(hw_spi_ss),
        .hw_spi_mosi(hw_spi_mosi),
        .hw_spi_miso(hw_spi_miso)
    );

    // Slave model: MISO bit k of the frame is miso_pat byte k/8, bit 7-k%8.
    always_comb begin
        mi = ((miso_idx / 8) * 8) + 7 - (miso_idx % 8);
        hw_spi_miso = (miso_idx < 64) ? miso_pat[6'(mi)] : 1'b0;
    end

    always @(posedge clk) begin
        sclk_prev <= hw_spi_clk;
        if (hw_spi_ss) miso_idx <= 0;
        else if (sclk_prev && !hw_spi_clk) miso_idx <= miso_idx + 1;
        if (!sclk_prev && hw_spi_clk) begin
            rise_cnt <= rise_cnt + 1;
            mosi_log <= {mosi_log[62:0], hw_spi_mosi};
        end
        if (!hw_spi_ss) ss_low_cnt <= ss_low_cnt + 1;
        if (rsp_valid) rv_cnt <= rv_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 500) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({cmd_ready, busy, rsp_valid, hw_spi_clk, hw_spi_ss, hw_spi_mosi} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000010",
                     {cmd_ready, busy, rsp_valid, hw_spi_clk, hw_spi_ss, hw_spi_mosi});
        end
        n_chk++;
        if (rsp_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b want 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_single();
        bit ok;
        int lat, b_rise, b_ss, b_rv;
        wait_ready(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL single_ready: got timeout want ready"); end
        b_rise = rise_cnt; b_ss = ss_low_cnt; b_rv = rv_cnt;
        miso_pat = 64'h3C;
        cmd_valid = 1'b1; cmd_len = 4'd1; cmd_data = 64'hA5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_data = '1; cmd_len = 4'd5;
        n_chk++;
        if ({cmd_ready, busy, hw_spi_ss, hw_spi_clk, hw_spi_mosi} !== 5'b01001) begin
            n_fail++;
            $display("FAIL single_setup: got %b want 01001",
                     {cmd_ready, busy, hw_spi_ss, hw_spi_clk, hw_spi_mosi});
        end
        wait_rsp(lat);
        n_chk++;
        if (lat !== 35) begin n_fail++; $display("FAIL single_latency: got %0d want 35", lat); end
        @(posedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", rsp_valid); end
        wait_ready(ok);
        n_chk++;
        if (rise_cnt - b_rise !== 8) begin
            n_fail++; $display("FAIL single_edges: got %0d want 8", rise_cnt - b_rise);
        end
        n_chk++;
        if (mosi_log[7:0] !== 8'hA5) begin
            n_fail++; $display("FAIL single_mosi: got %h want a5", mosi_log[7:0]);
        end
        n_chk++;
        if (ss_low_cnt - b_ss !== 34) begin
            n_fail++; $display("FAIL single_ss_low: got %0d want 34", ss_low_cnt - b_ss);
        end
        n_chk++;
        if (rsp_data !== 64'h3C) begin
            n_fail++; $display("FAIL single_rsp: got %h want 3c", rsp_data);
        end
        n_chk++;
        if (rv_cnt - b_rv !== 1) begin
            n_fail++; $display("FAIL single_rv_count: got %0d want 1", rv_cnt - b_rv);
        end
    endtask

    task automatic test_multi();
        bit ok;
        int lat, b_rise, b_rv;
        wait_ready(ok);
        b_rise = rise_cnt; b_rv = rv_cnt;
        miso_pat = 64'h1122334455667788;
        cmd_valid = 1'b1; cmd_len = 4'd3; cmd_data = 64'h0000_0000_00FF_8001;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat);
        n_chk++;
        if (lat !== 99) begin n_fail++; $display("FAIL multi_latency: got %0d want 99", lat); end
        wait_ready(ok);
        n_chk++;
        if (rise_cnt - b_rise !== 24) begin
            n_fail++; $display("FAIL multi_edges: got %0d want 24", rise_cnt - b_rise);
        end
        n_chk++;
        if (mosi_log[23:0] !== 24'h0180FF) begin
            n_fail++; $display("FAIL multi_mosi: got %h want 0180ff", mosi_log[23:0]);
        end
        n_chk++;
        if (rsp_data !== 64'h667788) begin
            n_fail++; $display("FAIL multi_rsp: got %h want 667788", rsp_data);
        end
        n_chk++;
        if (rv_cnt - b_rv !== 1) begin
            n_fail++; $display("FAIL multi_rv_count: got %0d want 1", rv_cnt - b_rv);
        end
    endtask

    task automatic test_empty();
        bit ok;
        int b_rise, b_ss;
        wait_ready(ok);
        b_rise = rise_cnt; b_ss = ss_low_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd0; cmd_data = 64'hFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_chk++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL empty_rsp_valid: got %b want 1", rsp_valid); end
        n_chk++;
        if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL empty_rsp_data: got %h want 0", rsp_data); end
        n_chk++;
        if ({cmd_ready, busy, hw_spi_ss, hw_spi_clk} !== 4'b1010) begin
            n_fail++;
            $display("FAIL empty_idle: got %b want 1010", {cmd_ready, busy, hw_spi_ss, hw_spi_clk});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pulse: got %b want 0", rsp_valid); end
        repeat (5) @(negedge clk);
        n_chk++;
        if ((rise_cnt - b_rise) + (ss_low_cnt - b_ss) !== 0) begin
            n_fail++;
            $display("FAIL empty_no_spi: got edges=%0d ss_low=%0d want 0", rise_cnt - b_rise, ss_low_cnt - b_ss);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        int lat, b_rise;
        wait_ready(ok);
        b_rise = rise_cnt;
        miso_pat = 64'h0123456789ABCDEF;
        cmd_valid = 1'b1; cmd_len = 4'd12; cmd_data = 64'h8877665544332211;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat);
        n_chk++;
        if (lat !== 259) begin n_fail++; $display("FAIL clamp_latency: got %0d want 259", lat); end
        wait_ready(ok);
        n_chk++;
        if (rise_cnt - b_rise !== 64) begin
            n_fail++; $display("FAIL clamp_edges: got %0d want 64", rise_cnt - b_rise);
        end
        n_chk++;
        if (mosi_log !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL clamp_mosi: got %h want 1122334455667788", mosi_log);
        end
        n_chk++;
        if (rsp_data !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL clamp_rsp: got %h want 0123456789abcdef", rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat, gap, b_rise, b_rv;
        wait_ready(ok);
        b_rise = rise_cnt; b_rv = rv_cnt;
        miso_pat = 64'h0;
        cmd_valid = 1'b1; cmd_len = 4'd1; cmd_data = 64'h5A;
        @(posedge clk);
        #1;
        n_chk++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_not_ready: got %b want 0", cmd_ready); end
        @(negedge clk);
        cmd_data = 64'hC3;
        wait_rsp(lat);
        n_chk++;
        if (lat !== 35) begin n_fail++; $display("FAIL b2b_latency1: got %0d want 35", lat); end
        gap = 1;
        while (gap < 100) begin
            @(posedge clk);
            #1;
            if (!hw_spi_ss) break;
            gap++;
        end
        n_chk++;
        if (gap !== GAP_CYCLES) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want %0d", gap, GAP_CYCLES);
        end
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b want 1", busy); end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        n_chk++;
        if (lat !== 35) begin n_fail++; $display("FAIL b2b_latency2: got %0d want 35", lat); end
        wait_ready(ok);
        repeat (10) @(negedge clk);
        n_chk++;
        if (rise_cnt - b_rise !== 16) begin
            n_fail++; $display("FAIL b2b_edges: got %0d want 16", rise_cnt - b_rise);
        end
        n_chk++;
        if (rv_cnt - b_rv !== 2) begin
            n_fail++; $display("FAIL b2b_rv_count: got %0d want 2", rv_cnt - b_rv);
        end
        n_chk++;
        if (mosi_log[15:0] !== 16'h5AC3) begin
            n_fail++; $display("FAIL b2b_mosi: got %h want 5ac3", mosi_log[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat, n, b_rise, b_rv;
        wait_ready(ok);
        b_rise = rise_cnt; b_rv = rv_cnt;
        miso_pat = 64'hFF;
        cmd_valid = 1'b1; cmd_len = 4'd2; cmd_data = 64'h00A5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while ((rise_cnt - b_rise) < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if ({hw_spi_clk, hw_spi_mosi} !== 2'b11) begin
            n_fail++; $display("FAIL mid_bit5: got %b want 11", {hw_spi_clk, hw_spi_mosi});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({hw_spi_ss, hw_spi_clk, hw_spi_mosi, busy, rsp_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b want 10000",
                     {hw_spi_ss, hw_spi_clk, hw_spi_mosi, busy, rsp_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (rv_cnt - b_rv !== 0) begin
            n_fail++; $display("FAIL mid_no_rsp: got %0d want 0", rv_cnt - b_rv);
        end
        wait_ready(ok);
        b_rise = rise_cnt;
        miso_pat = 64'h69;
        cmd_valid = 1'b1; cmd_len = 4'd1; cmd_data = 64'h96;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat);
        n_chk++;
        if (lat !== 35) begin n_fail++; $display("FAIL mid_after_latency: got %0d want 35", lat); end
        wait_ready(ok);
        n_chk++;
        if (mosi_log[7:0] !== 8'h96 || rise_cnt - b_rise !== 8) begin
            n_fail++;
            $display("FAIL mid_after_mosi: got %h/%0d want 96/8", mosi_log[7:0], rise_cnt - b_rise);
        end
        n_chk++;
        if (rsp_data !== 64'h69) begin
            n_fail++; $display("FAIL mid_after_rsp: got %h want 69", rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
